// File: rtl/conv_pool_stream.sv
// conv_pool_stream: streaming 3x3 valid convolution with optional 2x2 max-pool.
// Define CONV_POOL_MAXPOOL_EN to build the pool stage (LAT 4, otherwise LAT 3).
module conv_pool_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   In_IFM,
  input  logic signed [DATA_W-1:0]   In_Weight,
  input  logic                       relu_en,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [2*DATA_W+3:0] Out_OFM,
  output logic                       frame_done
);
  localparam int OUT_W = 2*DATA_W+4;
  localparam int PRW   = 2*DATA_W;
  localparam int NB    = IMG_W*IMG_H;
`ifdef CONV_POOL_MAXPOOL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      state;
  logic [15:0] beat;
  logic [7:0]  col, row;
  logic [1:0]  fcnt;
  logic        acc;

  logic signed [DATA_W-1:0] w   [9];
  logic signed [DATA_W-1:0] win [9];
  logic signed [DATA_W-1:0] lb1 [IMG_W];
  logic signed [DATA_W-1:0] lb2 [IMG_W];
  logic signed [PRW-1:0]    prod [9];
  logic signed [OUT_W-1:0]  tree, sum_q, c_out;
  logic                     relu, win_v, mul_v, sum_v, cv;

  assign acc = in_valid && in_ready;

  // frame sequencing: beat/row/col tracking, flush timer, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      col        <= '0;
      row        <= '0;
      fcnt       <= '0;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (acc) begin
            if (beat == 16'(NB-1)) begin
              state    <= FLUSH;
              beat     <= '0;
              col      <= '0;
              row      <= '0;
              fcnt     <= '0;
              in_ready <= 1'b0;
            end else begin
              state <= RUN;
              beat  <= beat + 16'd1;
              if (col == 8'(IMG_W-1)) begin
                col <= '0;
                row <= row + 8'd1;
              end else begin
                col <= col + 8'd1;
              end
            end
          end
        end
        FLUSH: begin
          if (fcnt == 2'(LAT-1)) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // per-frame weight and relu capture on the leading beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relu <= 1'b0;
      for (int k = 0; k < 9; k++) w[k] <= '0;
    end else if (acc) begin
      if (beat == 16'd0) relu <= relu_en;
      for (int k = 0; k < 9; k++)
        if (beat == 16'(k)) w[k] <= In_Weight;
    end
  end

  // line buffers and 3x3 window; window tagged when it sits inside the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_v <= 1'b0;
      for (int k = 0; k < IMG_W; k++) begin
        lb1[k] <= '0;
        lb2[k] <= '0;
      end
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else begin
      win_v <= acc && (row >= 8'd2) && (col >= 8'd2);
      if (acc) begin
        lb1[0] <= In_IFM;
        lb2[0] <= lb1[IMG_W-1];
        for (int k = IMG_W-1; k > 0; k--) begin
          lb1[k] <= lb1[k-1];
          lb2[k] <= lb2[k-1];
        end
        for (int m = 0; m < 3; m++) begin
          win[m*3]   <= win[m*3+1];
          win[m*3+1] <= win[m*3+2];
        end
        win[2] <= lb2[IMG_W-1];
        win[5] <= lb1[IMG_W-1];
        win[8] <= In_IFM;
      end
    end
  end

  // full-precision products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_v <= 1'b0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
    end else begin
      mul_v <= win_v;
      for (int k = 0; k < 9; k++)
        prod[k] <= PRW'(win[k]) * PRW'(w[k]);
    end
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < 9; k++) tree = tree + OUT_W'(prod[k]);
  end

  // adder-tree register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_v <= 1'b0;
      sum_q <= '0;
    end else begin
      sum_v <= mul_v;
      sum_q <= tree;
    end
  end

  // conv result register with optional relu; zero when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv    <= 1'b0;
      c_out <= '0;
    end else begin
      cv    <= sum_v;
      c_out <= '0;
      if (sum_v) c_out <= (relu && sum_q[OUT_W-1]) ? '0 : sum_q;
    end
  end

`ifdef CONV_POOL_MAXPOOL_EN
  localparam int CW = IMG_W-2;
  localparam int CH = IMG_H-2;
  localparam int PW = CW/2;
  localparam int PH = CH/2;
  localparam int IW = (PW > 1) ? $clog2(PW) : 1;

  logic [7:0]              pi, pj;
  logic [IW-1:0]           idx;
  logic                    inb, pv;
  logic signed [OUT_W-1:0] tmp, p_out, cur, rb;
  logic signed [OUT_W-1:0] rowbuf [PW];

  function automatic logic signed [OUT_W-1:0] smax(
    input logic signed [OUT_W-1:0] a,
    input logic signed [OUT_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign idx = pj[IW:1];
  assign inb = (pi < 8'(2*PH)) && (pj < 8'(2*PW));
  assign rb  = rowbuf[idx];

  // running maximum for the current conv position
  always_comb begin
    cur = c_out;
    if (pj[0])      cur = smax(tmp, c_out);
    else if (pi[0]) cur = smax(rb, c_out);
  end

  // 2x2 pooling: even rows fill the row-max buffer, odd rows emit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pi    <= '0;
      pj    <= '0;
      tmp   <= '0;
      pv    <= 1'b0;
      p_out <= '0;
      for (int k = 0; k < PW; k++) rowbuf[k] <= '0;
    end else begin
      pv    <= 1'b0;
      p_out <= '0;
      if (cv) begin
        if (pj == 8'(CW-1)) begin
          pj <= '0;
          pi <= (pi == 8'(CH-1)) ? 8'd0 : pi + 8'd1;
        end else begin
          pj <= pj + 8'd1;
        end
        if (inb) begin
          if (!pj[0])      tmp <= cur;
          else if (!pi[0]) rowbuf[idx] <= cur;
          else begin
            pv    <= 1'b1;
            p_out <= cur;
          end
        end
      end
    end
  end

  assign out_valid = pv;
  assign Out_OFM   = p_out;
`else
  assign out_valid = cv;
  assign Out_OFM   = c_out;
`endif

endmodule
